// File: rtl/modexp_scheduler_if.sv
// Handshake/bus bundle between the RSA register block,
// the modexp scheduler and the shared Montgomery multiplier.
//
// Request side:
//   start, in_xm, in_onem, in_m, in_e, in_ebits -> scheduler
//   busy, done, result <- scheduler
// Multiplier side:
//   mont_start, mont_a, mont_b, mont_m <- scheduler
//   mont_result, mont_done -> scheduler
interface modexp_scheduler_if #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int EB_W      = 11
);
  logic                 start;
  logic [WIDTH-1:0]     in_xm;
  logic [WIDTH-1:0]     in_onem;
  logic [WIDTH-1:0]     in_m;
  logic [EXP_WIDTH-1:0] in_e;
  logic [EB_W-1:0]      in_ebits;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;
  logic                 mont_start;
  logic [WIDTH-1:0]     mont_a;
  logic [WIDTH-1:0]     mont_b;
  logic [WIDTH-1:0]     mont_m;
  logic [WIDTH-1:0]     mont_result;
  logic                 mont_done;

  modport slave (
    input  start,
    input  in_xm,
    input  in_onem,
    input  in_m,
    input  in_e,
    input  in_ebits,
    output busy,
    output done,
    output result,
    output mont_start,
    output mont_a,
    output mont_b,
    output mont_m,
    input  mont_result,
    input  mont_done
  );

  modport master (
    output start,
    output in_xm,
    output in_onem,
    output in_m,
    output in_e,
    output in_ebits,
    input  busy,
    input  done,
    input  result,
    input  mont_start,
    input  mont_a,
    input  mont_b,
    input  mont_m,
    output mont_result,
    output mont_done
  );
endinterface

// File: rtl/modexp_scheduler.sv
// Left-to-right square-and-multiply sequencer driving one
// shared Montgomery multiplier, ending with a multiply-by-1.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : modexp_scheduler_if.slave (request + multiplier)
module modexp_scheduler #(
  parameter int WIDTH     = 1024,
  parameter int EXP_WIDTH = 1024,
  parameter int EB_W      = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  modexp_scheduler_if.slave     bus
);

  localparam logic [EB_W-1:0] EMAX =
    EB_W'(EXP_WIDTH);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);
  localparam logic [EXP_WIDTH-1:0] E_ONE =
    EXP_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEXT,
    S_SQ_WAIT,
    S_MUL_WAIT,
    S_FIN_WAIT,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]     r_xm;
  logic [WIDTH-1:0]     r_m;
  logic [EXP_WIDTH-1:0] r_e;
  logic [EB_W-1:0]      r_i;
  logic [WIDTH-1:0]     r_result;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_mont_start;
  logic [WIDTH-1:0]     r_mont_a;
  logic [WIDTH-1:0]     r_mont_b;

  logic             w_accept;
  logic             w_issue;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic             w_res_ld;
  logic             w_dec;
  logic             w_done_set;
  logic             w_md;
  logic             w_ebit;
  logic             w_i_nz;
  logic [EB_W-1:0]  w_eb_lat;

  // The multiplier cannot answer in the cycle it is
  // started, so a done coinciding with our own start
  // pulse is stale/spurious and dropped.
  assign w_md   = bus.mont_done & ~r_mont_start;
  assign w_ebit = |(r_e & (E_ONE << r_i));
  assign w_i_nz = (r_i != '0);
  assign w_eb_lat =
    (bus.in_ebits > EMAX) ? EMAX : bus.in_ebits;

  // The accumulator lives in mont_a: every operation
  // issued after a completed multiply takes the fresh
  // product as operand A, so the next operation is
  // chosen and registered at the consuming edge. The
  // pulse then shows during NEXT (or first MUL_WAIT).
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_op_a      = bus.mont_result;
    w_op_b      = bus.mont_result;
    w_res_ld    = 1'b0;
    w_dec       = 1'b0;
    w_done_set  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_issue     = 1'b1;
          w_op_a      = bus.in_onem;
          w_op_b      = (w_eb_lat != '0) ?
                        bus.in_onem : ONE;
          w_state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (w_i_nz) begin
          w_dec       = 1'b1;
          w_state_nxt = S_SQ_WAIT;
        end else begin
          w_state_nxt = S_FIN_WAIT;
        end
      end
      S_SQ_WAIT: begin
        if (w_md) begin
          w_issue = 1'b1;
          if (w_ebit) begin
            w_op_b      = r_xm;
            w_state_nxt = S_MUL_WAIT;
          end else begin
            w_op_b      = w_i_nz ?
                          bus.mont_result : ONE;
            w_state_nxt = S_NEXT;
          end
        end
      end
      S_MUL_WAIT: begin
        if (w_md) begin
          w_issue     = 1'b1;
          w_op_b      = w_i_nz ?
                        bus.mont_result : ONE;
          w_state_nxt = S_NEXT;
        end
      end
      S_FIN_WAIT: begin
        if (w_md) begin
          w_res_ld    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done_set  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xm         <= '0;
      r_m          <= '0;
      r_e          <= '0;
      r_i          <= '0;
      r_result     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_mont_start <= 1'b0;
      r_mont_a     <= '0;
      r_mont_b     <= '0;
    end else begin
      r_mont_start <= w_issue;
      r_done       <= w_done_set;
      if (w_issue) begin
        r_mont_a <= w_op_a;
        r_mont_b <= w_op_b;
      end
      if (w_accept) begin
        r_xm   <= bus.in_xm;
        r_m    <= bus.in_m;
        r_e    <= bus.in_e;
        r_i    <= w_eb_lat;
        r_busy <= 1'b1;
      end
      if (w_dec)
        r_i <= r_i - EB_W'(1);
      if (w_res_ld)
        r_result <= bus.mont_result;
      if (w_done_set)
        r_busy <= 1'b0;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.result     = r_result;
  assign bus.mont_start = r_mont_start;
  assign bus.mont_a     = r_mont_a;
  assign bus.mont_b     = r_mont_b;
  assign bus.mont_m     = r_m;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Scoreboard bench for modexp_scheduler with a behavioural
// Montgomery multiplier of variable latency.
module tb_modexp_scheduler;
  localparam int W   = 16;
  localparam int EW  = 16;
  localparam int EBW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  modexp_scheduler_if #(
    .WIDTH(W), .EXP_WIDTH(EW), .EB_W(EBW)
  ) bus ();

  modexp_scheduler #(
    .WIDTH(W), .EXP_WIDTH(EW), .EB_W(EBW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [15:0] res;
    int          pulses;
  } exp_t;

  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int pulse_cnt = 0;
  int lat_mode = 0;
  bit spur_next = 0;
  logic [15:0] first_a, first_b, last_b;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // a*b*2^-16 mod m, bit-serial reduction
  function automatic logic [15:0] mont(
      input logic [15:0] a, input logic [15:0] b,
      input logic [15:0] m);
    logic [63:0] t;
    t = 64'(a) * 64'(b);
    for (int k = 0; k < 16; k++) begin
      if (t[0]) t = t + 64'(m);
      t = t >> 1;
    end
    if (t >= 64'(m)) t = t - 64'(m);
    return t[15:0];
  endfunction

  // right-to-left reference, normal domain
  function automatic logic [15:0] powmod(
      input logic [15:0] x, input logic [15:0] e,
      input int eb, input logic [15:0] m);
    logic [63:0] r, bs;
    r  = 64'd1 % 64'(m);
    bs = 64'(x) % 64'(m);
    for (int k = 0; k < eb; k++) begin
      if (e[k]) r = (r * bs) % 64'(m);
      bs = (bs * bs) % 64'(m);
    end
    return r[15:0];
  endfunction

  function automatic int popc(input logic [15:0] v,
                              input int eb);
    int c = 0;
    for (int k = 0; k < eb; k++)
      if (v[k]) c++;
    return c;
  endfunction

  // multiplier model
  initial begin : responder
    bit pend;
    int wcnt;
    logic [15:0] ca, cb, cm;
    pend = 0;
    wcnt = 0;
    bus.mont_done = 1'b0;
    bus.mont_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mont_done = 1'b0;
      if (reset) begin
        pend = 0;
      end else if (pend) begin
        chk("operand_hold",
            {15'd0, bus.mont_start,
             bus.mont_a, bus.mont_b, bus.mont_m},
            {16'd0, ca, cb, cm});
        if (wcnt == 0) begin
          bus.mont_result = mont(ca, cb, cm);
          bus.mont_done = 1'b1;
          pend = 0;
        end else begin
          wcnt--;
        end
      end else if (bus.mont_start) begin
        ca = bus.mont_a;
        cb = bus.mont_b;
        cm = bus.mont_m;
        pulse_cnt++;
        if (pulse_cnt == 1) begin
          first_a = ca;
          first_b = cb;
        end
        last_b = cb;
        wcnt = (lat_mode == 0) ?
               int'($urandom_range(7, 0)) :
               lat_mode - 1;
        pend = 1;
        if (spur_next) begin
          spur_next = 0;
          bus.mont_result = 16'hBEEF;
          bus.mont_done = 1'b1;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && bus.done) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: result %0h",
                   bus.result);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(bus.result), 64'(e.res));
          chk("pulses", 64'(pulse_cnt), 64'(e.pulses));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
      end
    end
  end

  task automatic run_job(
      input logic [15:0] m, input logic [15:0] x,
      input logic [15:0] e, input int eb,
      input int lt, input bit hold, input bit spur);
    logic [15:0] xr;
    logic [15:0] onem;
    int ee, np, k;
    ee = (eb > EW) ? EW : eb;
    onem = 16'(64'd65536 % 64'(m));
    xr = powmod(x, e, ee, m);
    np = ee + popc(e, ee) + 1;
    lat_mode = lt;
    bus.in_m = m;
    bus.in_xm = 16'((64'(x) << 16) % 64'(m));
    bus.in_onem = onem;
    bus.in_e = e;
    bus.in_ebits = EBW'(eb);
    exp_q.push_back('{res: xr, pulses: np});
    pulse_cnt = 0;
    spur_next = spur;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    k = 0;
    while (k < 3000 && bus.done !== 1'b1) begin
      @(posedge clk);
      #2;
      k++;
    end
    bus.start = 1'b0;
    if (k >= 3000) begin
      n_chk++;
      n_fail++;
      $display("FAIL job_timeout: m %0d x %0d e %0h",
               m, x, e);
      exp_q.delete();
    end
    chk("first_a", 64'(first_a), 64'(onem));
    chk("first_b", 64'(first_b),
        (ee != 0) ? 64'(onem) : 64'd1);
    chk("final_b_one", 64'(last_b), 64'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("no_extra_pulses", 64'(pulse_cnt), 64'(np));
    chk("result_held", 64'(bus.result), 64'(xr));
    chk("idle_not_busy", 64'(bus.busy), 64'd0);
  endtask

  initial begin : driver
    int k;
    bus.start = 1'b0;
    bus.in_xm = '0;
    bus.in_onem = '0;
    bus.in_m = '0;
    bus.in_e = '0;
    bus.in_ebits = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_mstart", 64'(bus.mont_start), 64'd0);
    chk("rst_result", 64'(bus.result), 64'd0);
    chk("rst_ops",
        {16'd0, bus.mont_a, bus.mont_b, bus.mont_m},
        64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // 3^5 mod 197 over 3 bits
    run_job(16'd197, 16'd3, 16'd5, 3, 0, 0, 0);
    chk("t1_46", 64'(bus.result), 64'd46);
    chk("t1_6mul", 64'(pulse_cnt), 64'd6);

    // ebits = 0: only the conversion multiply
    run_job(16'd197, 16'd3, 16'd0, 0, 0, 0, 0);
    chk("t2_one", 64'(bus.result), 64'd1);
    chk("t2_1mul", 64'(pulse_cnt), 64'd1);

    // Fermat: 2^0xFFF0 mod 65521
    run_job(16'd65521, 16'd2, 16'hFFF0, 16, 0, 0, 0);
    chk("t3_one", 64'(bus.result), 64'd1);
    chk("t3_29mul", 64'(pulse_cnt), 64'd29);

    // reset while squaring
    lat_mode = 6;
    bus.in_m = 16'd197;
    bus.in_onem = 16'(64'd65536 % 64'd197);
    bus.in_xm = 16'((64'd3 << 16) % 64'd197);
    bus.in_e = 16'd5;
    bus.in_ebits = 5'd3;
    pulse_cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (k < 50 && pulse_cnt < 1) begin
      @(negedge clk);
      k++;
    end
    chk("t4_started", 64'(pulse_cnt), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t4_busy", 64'(bus.busy), 64'd0);
    chk("t4_done", 64'(bus.done), 64'd0);
    chk("t4_mstart", 64'(bus.mont_start), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("t4_dropped", 64'(bus.busy), 64'd0);
    run_job(16'd197, 16'd3, 16'd5, 3, 0, 0, 0);
    chk("t4_46", 64'(bus.result), 64'd46);

    // start held high, spurious done in NEXT
    run_job(16'd197, 16'd3, 16'd5, 3, 0, 1, 1);
    chk("t5_46", 64'(bus.result), 64'd46);

    // extreme multiplier latencies
    run_job(16'd197, 16'd3, 16'd5, 3, 1, 0, 0);
    chk("t6a_46", 64'(bus.result), 64'd46);
    run_job(16'd197, 16'd3, 16'd5, 3, 40, 0, 0);
    chk("t6b_46", 64'(bus.result), 64'd46);

    // ebits above EXP_WIDTH clamps; M = 1
    run_job(16'd40961, 16'd12345, 16'hA5C3, 31, 0, 0, 0);
    run_job(16'd1, 16'd0, 16'h1234, 9, 0, 0, 0);
    run_job(16'd1, 16'd0, 16'h0, 0, 0, 0, 0);

    for (int j = 0; j < 40; j++) begin
      logic [15:0] m, x, e;
      m = 16'($urandom_range(65535, 1)) | 16'd1;
      if (j % 13 == 0) m = 16'd1;
      x = 16'($urandom % 32'(m));
      e = 16'($urandom);
      run_job(m, x, e, int'($urandom_range(16, 0)),
              0, 1'($urandom), 1'($urandom));
    end

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
